// File: rtl/seq_mul_cell.sv
// Multi-cycle unsigned shift-add multiplier with valid/ready handshakes.
// It takes one operand pair at a time and always spends WIDTH_B cycles on it.
module seq_mul_cell #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [WIDTH_A+WIDTH_B-1:0] C
);

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = $clog2(WIDTH_B + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH_B - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; valid must be held until that edge.
    state_t          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [PW-1:0]   c_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH_B-1:0] mult_q;
    logic [CW-1:0]   count_q;

    always_comb begin
        acc_d = acc_q;
        if (mult_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mult_q      <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID && in_ready_q) begin
                        mcand_q    <= PW'(A);
                        mult_q     <= B;
                        acc_q      <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_q >> 1;
                    count_q <= count_q + CW'(1);
                    // The final partial product goes straight into C so it is
                    // valid in the same cycle OUT_VALID rises.
                    if (count_q == LAST) begin
                        c_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign C         = c_q;

endmodule

// File: tb/tb_seq_mul_cell.sv
// Bench for seq_mul_cell: directed vectors on a 4x4 cell plus exhaustive
// sweeps of 1x1 and 2x3 cells, checked through per-instance expected queues.
module tb_seq_mul_cell;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // 4x4 instance
    logic       iv0, ir0, ov0, or0;
    logic [3:0] a0, b0;
    logic [7:0] c0;
    // 1x1 instance
    logic       iv1, ir1, ov1, or1;
    logic [0:0] a1, b1;
    logic [1:0] c1;
    // 2x3 instance
    logic       iv2, ir2, ov2, or2;
    logic [1:0] a2;
    logic [2:0] b2;
    logic [4:0] c2;

    seq_mul_cell #(.WIDTH_A(4), .WIDTH_B(4)) u0 (
        .CLK(clk), .RST(rst), .IN_VALID(iv0), .IN_READY(ir0), .A(a0), .B(b0),
        .OUT_VALID(ov0), .OUT_READY(or0), .C(c0)
    );
    seq_mul_cell #(.WIDTH_A(1), .WIDTH_B(1)) u1 (
        .CLK(clk), .RST(rst), .IN_VALID(iv1), .IN_READY(ir1), .A(a1), .B(b1),
        .OUT_VALID(ov1), .OUT_READY(or1), .C(c1)
    );
    seq_mul_cell #(.WIDTH_A(2), .WIDTH_B(3)) u2 (
        .CLK(clk), .RST(rst), .IN_VALID(iv2), .IN_READY(ir2), .A(a2), .B(b2),
        .OUT_VALID(ov2), .OUT_READY(or2), .C(c2)
    );

    logic [7:0] exp0_q[$];
    logic [1:0] exp1_q[$];
    logic [4:0] exp2_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s: actual=%0d required=none", name, act);
    endtask

    // ---------------- monitors ----------------
    int         acc_cyc0, acc_cyc1, acc_cyc2;
    logic       prev_ov0, prev_ov1, prev_ov2;
    logic [7:0] last0;
    logic       ready_chk0;

    always @(negedge clk) begin
        if (rst) begin
            last0 = '0;
            prev_ov0 = 1'b0;
            ready_chk0 = 1'b0;
        end else begin
            if (ready_chk0) begin
                check("u0_in_ready_after_done", ir0, 1);
                ready_chk0 = 1'b0;
            end
            if (iv0 && ir0) acc_cyc0 = cyc;
            if (ov0) begin
                check("u0_in_ready_low_in_done", ir0, 0);
                if (!prev_ov0) check("u0_latency", cyc - acc_cyc0, 5);
                if (exp0_q.size() == 0) fail_now("u0_unexpected_output", c0);
                else begin
                    check("u0_product", c0, exp0_q[0]);
                    if (or0) begin
                        last0 = exp0_q.pop_front();
                        ready_chk0 = 1'b1;
                    end
                end
            end else if (ir0) begin
                check("u0_c_retained", c0, last0);
            end
            prev_ov0 = ov0;
        end
    end

    always @(negedge clk) begin
        if (rst) prev_ov1 = 1'b0;
        else begin
            if (iv1 && ir1) acc_cyc1 = cyc;
            if (ov1) begin
                if (!prev_ov1) check("u1_latency", cyc - acc_cyc1, 2);
                if (exp1_q.size() == 0) fail_now("u1_unexpected_output", c1);
                else begin
                    check("u1_product", c1, exp1_q[0]);
                    if (or1) void'(exp1_q.pop_front());
                end
            end
            prev_ov1 = ov1;
        end
    end

    always @(negedge clk) begin
        if (rst) prev_ov2 = 1'b0;
        else begin
            if (iv2 && ir2) acc_cyc2 = cyc;
            if (ov2) begin
                if (!prev_ov2) check("u2_latency", cyc - acc_cyc2, 4);
                if (exp2_q.size() == 0) fail_now("u2_unexpected_output", c2);
                else begin
                    check("u2_product", c2, exp2_q[0]);
                    if (or2) void'(exp2_q.pop_front());
                end
            end
            prev_ov2 = ov2;
        end
    end

    // ---------------- drivers ----------------
    // Each issue task leaves IN_VALID high; the caller lowers it when done.
    task automatic issue0(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input bit push);
        int n = 0;
        iv0 = 1'b1; a0 = a; b0 = b;
        @(negedge clk);
        while (!ir0 && n < 100) begin @(negedge clk); n++; end
        if (!ir0) fail_now("u0_accept_timeout", n);
        else if (push) exp0_q.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic issue1(input logic [0:0] a, input logic [0:0] b, input logic [1:0] exp);
        int n = 0;
        iv1 = 1'b1; a1 = a; b1 = b;
        @(negedge clk);
        while (!ir1 && n < 100) begin @(negedge clk); n++; end
        if (!ir1) fail_now("u1_accept_timeout", n);
        else exp1_q.push_back(exp);
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    task automatic issue2(input logic [1:0] a, input logic [2:0] b, input logic [4:0] exp);
        int n = 0;
        iv2 = 1'b1; a2 = a; b2 = b;
        @(negedge clk);
        while (!ir2 && n < 100) begin @(negedge clk); n++; end
        if (!ir2) fail_now("u2_accept_timeout", n);
        else exp2_q.push_back(exp);
        @(posedge clk); #1;
        iv2 = 1'b0;
    endtask

    task automatic drain_all();
        int  n = 0;
        bit  busy = 1'b1;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
            busy = (exp0_q.size() + exp1_q.size() + exp2_q.size() != 0) || !(ir0 && ir1 && ir2);
        end
        if (busy) fail_now("drain_timeout", exp0_q.size() + exp1_q.size() + exp2_q.size());
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wait_n;
        rst = 1'b1;
        iv0 = 1'b0; a0 = '0; b0 = '0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b1;
        iv2 = 1'b0; a2 = '0; b2 = '0; or2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_u0_in_ready", ir0, 1);
        check("rst_u0_out_valid", ov0, 0);
        check("rst_u0_c", c0, 0);
        check("rst_u1_in_ready", ir1, 1);
        check("rst_u1_out_valid", ov1, 0);
        check("rst_u1_c", c1, 0);
        check("rst_u2_in_ready", ir2, 1);
        check("rst_u2_out_valid", ov2, 0);
        check("rst_u2_c", c2, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // full-scale operands
        issue0(4'd15, 4'd15, 8'd225, 1'b1);
        iv0 = 1'b0;
        drain_all();

        // zero multiplier, then zero multiplicand
        issue0(4'd9, 4'd0, 8'd0, 1'b1);
        iv0 = 1'b0;
        drain_all();
        issue0(4'd0, 4'd11, 8'd0, 1'b1);
        iv0 = 1'b0;
        drain_all();

        // backpressure: hold OUT_READY low for 10 cycles in DONE
        or0 = 1'b0;
        issue0(4'd6, 4'd7, 8'd42, 1'b1);
        iv0 = 1'b0;
        wait_n = 0;
        while (!ov0 && wait_n < 50) begin @(negedge clk); wait_n++; end
        if (!ov0) fail_now("bp_out_valid_timeout", wait_n);
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid_held", ov0, 1);
        end
        @(posedge clk); #1;
        or0 = 1'b1;
        drain_all();

        // back-to-back with IN_VALID held high
        issue0(4'd3, 4'd5, 8'd15, 1'b1);
        issue0(4'd15, 4'd1, 8'd15, 1'b1);
        issue0(4'd10, 4'd12, 8'd120, 1'b1);
        iv0 = 1'b0;
        drain_all();

        // reset two cycles into a multiplication
        issue0(4'd13, 4'd13, 8'd169, 1'b0);
        iv0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", ir0, 1);
        check("midrst_out_valid", ov0, 0);
        check("midrst_c", c0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue0(4'd2, 4'd3, 8'd6, 1'b1);
        iv0 = 1'b0;
        drain_all();

        // exhaustive sweeps of the small cells
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
                issue1(1'(a), 1'(b), 2'(a & b));
                drain_all();
            end
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 8; b++) begin
                issue2(2'(a), 3'(b), 5'(a * b));
                drain_all();
            end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mul_cell.md
Name: seq_mul_cell

Overview:
- Multi-cycle, unsigned shift-add multiplier. It is the technology-mapping stage that consumes the generic MUL_N_M cells emitted by synthesis.
- Each MUL_N_M instance is replaced by one seq_mul_cell with WIDTH_A=N and WIDTH_B=M. Product width is N+M.
- A valid/ready handshake carries operands in and the product out, so the cell can sit in a pipelined datapath.
- One multiplication is in flight at a time.

Parameters:
- WIDTH_A, 4, width of operand A (≥1).
- WIDTH_B, 4, width of operand B (≥1). This equals the number of iteration cycles.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operands A/B are valid.
- IN_READY  output  1  cell can accept operands.
- A  input  WIDTH_A  multiplicand, unsigned.
- B  input  WIDTH_B  multiplier, unsigned.
- OUT_VALID  output  1  C holds a completed product.
- OUT_READY  input  1  consumer accepts C.
- C  output  WIDTH_A+WIDTH_B  product A*B, unsigned, exact (no truncation).

Behaviour:
- Reset (async assert, sync release): state=IDLE, IN_READY=1, OUT_VALID=0, C=0, internal accumulator, operand registers and counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY, latch A into a multiplicand register zero-extended to WIDTH_A+WIDTH_B, latch B into a shift register, clear the accumulator, set count=0, go to RUN.
  - A and B are sampled only on that edge; later changes are ignored.
- RUN:
  - IN_READY=0, OUT_VALID=0.
  - Each cycle: if B_reg[0]=1, acc += mcand; then mcand <<= 1, B_reg >>= 1, count++.
  - After WIDTH_B RUN cycles (count reaches WIDTH_B-1 and is processed), go to DONE.
  - No early termination on a zero multiplier; latency is fixed.
- DONE:
  - OUT_VALID=1, C=acc, IN_READY=0.
  - C stays stable while OUT_VALID=1 and OUT_READY=0 (unbounded backpressure).
  - On OUT_READY=1, go to IDLE; OUT_VALID drops on the next cycle.
  - C retains the last product in IDLE until the next DONE.
- Latency: handshake edge at cycle 0 gives OUT_VALID=1 in cycle WIDTH_B+1. Minimum initiation interval is WIDTH_B+2 cycles.
- Simultaneous events:
  - IN_VALID during RUN/DONE is ignored and not queued; the producer must hold it.
  - OUT_READY while OUT_VALID=0 has no effect.
- Arithmetic:
  - The accumulator is WIDTH_A+WIDTH_B bits and cannot overflow, since max (2^WA-1)(2^WB-1) < 2^(WA+WB).
  - Counter width is clog2(WIDTH_B+1).
- WIDTH_B=1: RUN lasts exactly one cycle.
- WIDTH_A=WIDTH_B=1: C is 2 bits with C[1]=0 always.
- Reset mid-operation (RUN or DONE): immediate abort to the reset values. The partial product is discarded and no OUT_VALID pulse is produced.
- Combinational paths: no input-to-output path. IN_READY and OUT_VALID are decoded from registered state only.

Test Plan:
- Defaults, A=15, B=15, OUT_READY=1 → OUT_VALID rises 5 cycles after accept, C=8'd225, IN_READY back to 1 the cycle after completion.
- Defaults, A=4'd9, B=4'd0 → C=0 after full fixed latency (5 cycles). Then A=0, B=4'd11 → C=0.
- Backpressure: A=6, B=7, OUT_READY held 0 for 10 cycles → OUT_VALID=1 and C=42 stable throughout, IN_READY=0. Release → one transfer, then IDLE.
- Back-to-back: IN_VALID held high with pairs (3,5), (15,1), (10,12), OUT_READY=1 → C sequence 15, 15, 120. Each pair is accepted only in IDLE; none is lost or duplicated.
- Reset mid-RUN: RST asserted 2 cycles after accepting (13,13) → outputs at reset values immediately, no OUT_VALID. A subsequent (2,3) yields C=6.
- Parameter sweep: WIDTH_A=1, WIDTH_B=1 → exhaustive check of all 4 combinations (C=A&B, 2 bits, latency 2). WIDTH_A=2, WIDTH_B=3 → exhaustive 32 combinations against the A*B reference, 5-bit C.
